// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: turns EX/MEM load/store control into a single request
// pulse to a stallable data memory, stalls the pipeline until done, flags errors.
module mem_access_ctrl #(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              err,
    input  logic              Flush,
    input  logic              MemRead_EXMEM,
    input  logic              MemWrite_EXMEM,
    input  logic [DATA_W-1:0] addr_EXMEM,
    input  logic [DATA_W-1:0] wdata_EXMEM,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Stall_disable,
    output logic [DATA_W-1:0] MemReadRst_MEMWB_in,
    output logic              Err_MEMWB_in
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              both_q;

    logic access, misaligned, both, issue, in_wait, at_limit, timeout;

    assign mem_addr   = addr_EXMEM;
    assign mem_wdata  = wdata_EXMEM;
    assign access     = (MemRead_EXMEM | MemWrite_EXMEM) & ~Flush;
    assign misaligned = addr_EXMEM[0];
    assign both       = MemRead_EXMEM & MemWrite_EXMEM;
    assign issue      = (state == IDLE) & access & ~misaligned;
    assign in_wait    = (state == WAIT);
    assign at_limit   = (cnt == CNT_W'(MAX_WAIT - 1));
    assign timeout    = in_wait & at_limit & ~mem_done;

    always_comb begin
        mem_rd              = issue & MemRead_EXMEM & ~MemWrite_EXMEM;
        mem_wr              = issue & MemWrite_EXMEM;
        Stall_disable       = (issue & ~mem_done) | (in_wait & ~mem_done & ~at_limit);
        MemReadRst_MEMWB_in = rdata_q;
        if ((issue | in_wait) & mem_done)
            MemReadRst_MEMWB_in = mem_rdata;
        Err_MEMWB_in = 1'b0;
        if (state == IDLE)
            Err_MEMWB_in = access & (misaligned | both);
        else
            // A read+write conflict seen at issue is reported when the access retires.
            Err_MEMWB_in = timeout | (mem_done & both_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            both_q  <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (mem_done) begin
                            rdata_q <= mem_rdata;
                        end else begin
                            state  <= WAIT;
                            cnt    <= '0;
                            both_q <= both;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_done) begin
                        rdata_q <= mem_rdata;
                        state   <= IDLE;
                    end else if (at_limit) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
